restoring_divider: RTL and testbench

//  Sequential WIDTH-bit restoring divider: the inverse operation of the add-shift multiplier.

---
 rtl/restoring_divider.sv | 157 +++++++++++++++
 tb/tb_restoring_divider.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Sequential restoring divider: one shift cycle and one trial-subtract cycle per quotient bit.
// Optional signed (two's complement, truncating) mode enabled by defining SIGNED_DIV_EN.
module restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             LoadDivisor,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

`ifdef SIGNED_DIV_EN
  typedef enum logic [2:0] {
    S_HOLD, S_LOAD, S_INIT, S_SHIFT, S_SUB, S_FIXUP, S_FINISHED
  } state_t;
`else
  typedef enum logic [2:0] {
    S_HOLD, S_LOAD, S_INIT, S_SHIFT, S_SUB, S_FINISHED
  } state_t;
`endif

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_d;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH:0]     r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   w_d_abs;
  logic [WIDTH-1:0]   w_din_abs;
  logic [WIDTH:0]     w_trial;
  logic               w_last;

`ifdef SIGNED_DIV_EN
  logic               r_neg_n;
  logic               r_neg_d;
  assign w_d_abs   = r_d[WIDTH-1] ? (~r_d + WIDTH'(1)) : r_d;
  assign w_din_abs = Din[WIDTH-1] ? (~Din + WIDTH'(1)) : Din;
`else
  assign w_d_abs   = r_d;
  assign w_din_abs = Din;
`endif

  assign w_trial = r_rem - {1'b0, w_d_abs};
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_HOLD;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HOLD: begin
        if (Run)              w_state_next = S_INIT;
        else if (LoadDivisor) w_state_next = S_LOAD;
      end
      S_LOAD:  w_state_next = S_HOLD;
      S_INIT:  w_state_next = (w_d_abs == '0) ? S_FINISHED : S_SHIFT;
      S_SHIFT: w_state_next = S_SUB;
      S_SUB: begin
        if (w_last) begin
`ifdef SIGNED_DIV_EN
          w_state_next = S_FIXUP;
`else
          w_state_next = S_FINISHED;
`endif
        end else begin
          w_state_next = S_SHIFT;
        end
      end
`ifdef SIGNED_DIV_EN
      S_FIXUP: w_state_next = S_FINISHED;
`endif
      S_FINISHED: if (!Run) w_state_next = S_HOLD;
      default:    w_state_next = S_HOLD;
    endcase
  end

  // Datapath and registered status flags (decoded from the next state)
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_d     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
`ifdef SIGNED_DIV_EN
      r_neg_n <= 1'b0;
      r_neg_d <= 1'b0;
`endif
    end else begin
      r_busy <= (w_state_next != S_HOLD) && (w_state_next != S_LOAD) &&
                (w_state_next != S_FINISHED);
      r_done <= (w_state_next == S_FINISHED);
      case (r_state)
        S_LOAD: r_d <= Din;
        S_INIT: begin
          r_cnt <= '0;
`ifdef SIGNED_DIV_EN
          r_neg_n <= Din[WIDTH-1];
          r_neg_d <= r_d[WIDTH-1];
`endif
          if (w_d_abs == '0) begin
            r_quo <= '1;
            r_rem <= {1'b0, Din};
            r_dbz <= 1'b1;
          end else begin
            r_quo <= w_din_abs;
            r_rem <= '0;
            r_dbz <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_rem <= {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
          r_quo <= {r_quo[WIDTH-2:0], 1'b0};
        end
        S_SUB: begin
          if (!w_trial[WIDTH]) begin
            r_rem    <= w_trial;
            r_quo[0] <= 1'b1;
          end
          r_cnt <= r_cnt + CNT_W'(1);
        end
`ifdef SIGNED_DIV_EN
        S_FIXUP: begin
          if (r_neg_n ^ r_neg_d) r_quo <= ~r_quo + WIDTH'(1);
          if (r_neg_n)           r_rem <= {1'b0, ~r_rem[WIDTH-1:0] + WIDTH'(1)};
        end
`endif
        default: ;
      endcase
    end
  end

  assign Quotient  = r_quo;
  assign Remainder = r_rem[WIDTH-1:0];
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign DivByZero = r_dbz;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases plus random operands against
// a plain-arithmetic reference. Define SIGNED_DIV_EN to check the signed build.
module tb_restoring_divider;

  localparam int unsigned W = 8;
`ifdef SIGNED_DIV_EN
  localparam int LAT = 2 * W + 2;
`else
  localparam int LAT = 2 * W + 1;
`endif

  logic         clk = 1'b0;
  logic         reset, run, load;
  logic [W-1:0] din, quo, rem;
  logic         busy, done, dbz;
  int           n_checks = 0;
  int           n_pass = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .Clk(clk), .Reset(reset), .Run(run), .LoadDivisor(load), .Din(din),
    .Quotient(quo), .Remainder(rem), .Busy(busy), .Done(done), .DivByZero(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic void ref_div(input logic [W-1:0] d, input logic [W-1:0] n,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    int a, b;
    if (d == '0) begin
      q = '1;
      r = n;
    end else begin
`ifdef SIGNED_DIV_EN
      a = int'($signed(n));
      b = int'($signed(d));
`else
      a = int'(n);
      b = int'(d);
`endif
      q = W'(a / b);
      r = W'(a % b);
    end
  endfunction

  task automatic load_div(input logic [W-1:0] d);
    @(negedge clk); load = 1'b1; din = d;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
  endtask

  // Counts rising edges after the one that sampled Run until Done is seen
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  task automatic div_check(input string tag, input logic [W-1:0] d, input logic [W-1:0] n,
                           input logic reload);
    int lat;
    logic [W-1:0] eq, er;
    if (reload) load_div(d);
    @(negedge clk); run = 1'b1; din = n;
    wait_done(lat);
    ref_div(d, n, eq, er);
    check($sformatf("%s_lat", tag), 32'(lat), (d == '0) ? 32'd1 : 32'(LAT));
    check($sformatf("%s_q d=%0h n=%0h", tag, d, n), 32'(quo), 32'(eq));
    check($sformatf("%s_r d=%0h n=%0h", tag, d, n), 32'(rem), 32'(er));
    check($sformatf("%s_dbz", tag), 32'(dbz), (d == '0) ? 32'd1 : 32'd0);
    run = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [W-1:0] eq, er, rd, rn;
    reset = 1'b1; run = 1'b0; load = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    check("rst_flags", 32'({busy, done, dbz}), 32'd0);
    check("rst_qr", 32'({quo, rem}), 32'd0);
    reset = 1'b0;

`ifdef SIGNED_DIV_EN
    div_check("s_negd", 8'hF9, 8'd100, 1'b1);
    div_check("s_negn", 8'd7, 8'h9C, 1'b1);
    div_check("s_minneg", 8'hFF, 8'h80, 1'b1);
    div_check("s_bothneg", 8'hFD, 8'hF0, 1'b1);
`endif
    div_check("basic", 8'd7, 8'd100, 1'b1);
    div_check("divzero", 8'd0, 8'h5A, 1'b1);
    div_check("d1", 8'd1, 8'd255, 1'b1);
    div_check("d255", 8'd255, 8'd254, 1'b1);
    div_check("n0", 8'd3, 8'd0, 1'b1);

    // Reset in the middle of a division
    load_div(8'd7);
    @(negedge clk); run = 1'b1; din = 8'd100;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; run = 1'b0;
    check("abort_flags", 32'({busy, done, dbz}), 32'd0);
    check("abort_qr", 32'({quo, rem}), 32'd0);
    div_check("after_rst_d0", 8'd0, 8'h20, 1'b0);

    // LoadDivisor and Din changes while busy are ignored
    load_div(8'd7);
    @(negedge clk); run = 1'b1; din = 8'd100;
    repeat (3) @(negedge clk);
    load = 1'b1; din = 8'd9;
    repeat (3) @(negedge clk);
    load = 1'b0;
    wait_done(lat);
    check("busyload_lat", 32'(lat), 32'(LAT - 3 - 3));
    check("busyload_q", 32'(quo), 32'd14);
    check("busyload_r", 32'(rem), 32'd2);
    run = 1'b0;
    @(negedge clk);
    div_check("d_kept", 8'd7, 8'd100, 1'b0);

    // Run held high after Done must not restart
    @(negedge clk); run = 1'b1; din = 8'd200;
    wait_done(lat);
    ref_div(8'd7, 8'd200, eq, er);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check($sformatf("hold_%0d", i), 32'({busy, done, quo, rem}), 32'({2'b01, eq, er}));
    end
    run = 1'b0;
    @(negedge clk);
    check("back_to_hold", 32'({busy, done}), 32'd0);
    @(negedge clk); run = 1'b1; load = 1'b1; din = 8'd50;
    wait_done(lat);
    ref_div(8'd7, 8'd50, eq, er);
    check("runload_lat", 32'(lat), 32'(LAT));
    check("runload_q", 32'(quo), 32'(eq));
    check("runload_r", 32'(rem), 32'(er));
    run = 1'b0; load = 1'b0;
    @(negedge clk);
    div_check("runload_d_kept", 8'd7, 8'd50, 1'b0);

    // Random operands, with an occasional zero divisor
    for (int i = 0; i < 40; i++) begin
      rd = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
      rn = W'($urandom);
      div_check($sformatf("rnd%0d", i), rd, rn, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
